// File: rtl/complex_fu_pipe_if.sv
// Issue/writeback bundle for complex_fu_pipe: master drives issue and flush,
// slave (the functional unit) returns ready and the writeback packet.
interface complex_fu_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int FLAGS_W = 6,
    parameter int OPC_W   = 8,
    parameter int PHYS_W  = 7,
    parameter int AL_W    = 7
);
    logic               issue_valid_i;
    logic               ready_o;
    logic [OPC_W-1:0]   opcode_i;
    logic [DATA_W-1:0]  data2_i;
    logic [DATA_W-1:0]  alu_result_i;
    logic [FLAGS_W-1:0] alu_flags_i;
    logic [PHYS_W-1:0]  phys_dest_i;
    logic [AL_W-1:0]    al_id_i;
    logic               flush_i;
    logic               wb_valid_o;
    logic [DATA_W-1:0]  wb_data_o;
    logic [FLAGS_W-1:0] wb_flags_o;
    logic [PHYS_W-1:0]  wb_phys_o;
    logic [AL_W-1:0]    wb_al_id_o;

    modport master (
        output issue_valid_i, opcode_i, data2_i, alu_result_i, alu_flags_i,
               phys_dest_i, al_id_i, flush_i,
        input  ready_o, wb_valid_o, wb_data_o, wb_flags_o, wb_phys_o, wb_al_id_o
    );

    modport slave (
        input  issue_valid_i, opcode_i, data2_i, alu_result_i, alu_flags_i,
               phys_dest_i, al_id_i, flush_i,
        output ready_o, wb_valid_o, wb_data_o, wb_flags_o, wb_phys_o, wb_al_id_o
    );
endinterface

// File: rtl/complex_fu_pipe.sv
// Fixed-latency wrapper for the complex ALU: pipelined multiply class, blocking divide class.
// Optional macro COMPLEX_DIVZERO_EXC_EN forces a zero result and exception flags on divide by zero.
module complex_fu_pipe #(
    parameter int DATA_W  = 32,
    parameter int FLAGS_W = 6,
    parameter int OPC_W   = 8,
    parameter int PHYS_W  = 7,
    parameter int AL_W    = 7,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter logic [OPC_W-1:0] DIV_L  = OPC_W'(8'h44),
    parameter logic [OPC_W-1:0] DIV_H  = OPC_W'(8'h45),
    parameter logic [OPC_W-1:0] DIVU_L = OPC_W'(8'h46),
    parameter logic [OPC_W-1:0] DIVU_H = OPC_W'(8'h47)
) (
    input logic               clk,
    input logic               reset,
    complex_fu_pipe_if.slave  bus
);
    localparam int CNT_W = $clog2(DIV_LAT + 1);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [FLAGS_W-1:0] flags;
        logic [PHYS_W-1:0]  phys;
        logic [AL_W-1:0]    al_id;
    } pkt_t;

    typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             ready, div_done, is_div, mul_acc, div_acc;
    pkt_t             in_pkt, hold_pkt, tail_pkt, out_pkt;
    logic             tail_valid, out_valid;

    assign is_div  = bus.opcode_i inside {DIV_L, DIV_H, DIVU_L, DIVU_H};
    assign mul_acc = bus.issue_valid_i & ready & ~bus.flush_i & ~is_div;
    assign div_acc = bus.issue_valid_i & ready & ~bus.flush_i & is_div;

    always_comb begin
        in_pkt = '{data: bus.alu_result_i, flags: bus.alu_flags_i,
                   phys: bus.phys_dest_i, al_id: bus.al_id_i};
`ifdef COMPLEX_DIVZERO_EXC_EN
        if (is_div && bus.data2_i == '0) begin
            in_pkt.data  = '0;
            in_pkt.flags = FLAGS_W'(6'b010110);
        end
`endif
    end

`ifndef COMPLEX_DIVZERO_EXC_EN
    logic unused_data2;
    assign unused_data2 = ^bus.data2_i;
`endif

    // Output register is the last multiply stage, so the chain itself holds MUL_LAT-1 stages.
    generate
        if (MUL_LAT == 1) begin : g_direct
            assign tail_valid = mul_acc;
            assign tail_pkt   = in_pkt;
        end else begin : g_chain
            logic [MUL_LAT-2:0] valid;
            logic [MUL_LAT-1:0] valid_ext;
            pkt_t [MUL_LAT-2:0] pipe;
            pkt_t [MUL_LAT-1:0] pipe_ext;

            assign valid_ext = {valid, mul_acc};
            assign pipe_ext  = {pipe, in_pkt};

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)           valid <= '0;
                else if (bus.flush_i) valid <= '0;
                else                  valid <= valid_ext[MUL_LAT-2:0];
            end

            always_ff @(posedge clk) pipe <= pipe_ext[MUL_LAT-2:0];

            assign tail_valid = valid[MUL_LAT-2];
            assign tail_pkt   = pipe[MUL_LAT-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Counter is loaded with DIV_LAT; at 2 the output register is loaded so the
    // writeback lands DIV_LAT cycles after accept with ready already back high.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        div_done   = 1'b0;
        ready      = (state == DIV_IDLE);
        if (bus.flush_i) begin
            state_next = DIV_IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                DIV_IDLE: if (div_acc) begin
                    state_next = DIV_BUSY;
                    cnt_next   = CNT_W'(DIV_LAT);
                end
                DIV_BUSY: begin
                    cnt_next = cnt - 1'b1;
                    if (cnt == CNT_W'(2)) begin
                        div_done   = 1'b1;
                        state_next = DIV_IDLE;
                        cnt_next   = '0;
                    end
                end
                default: state_next = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) if (div_acc) hold_pkt <= in_pkt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_pkt   <= '0;
        end else if (bus.flush_i) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= tail_valid | div_done;
            if (tail_valid)    out_pkt <= tail_pkt;
            else if (div_done) out_pkt <= hold_pkt;
        end
    end

    assign bus.ready_o    = ready;
    assign bus.wb_valid_o = out_valid & ~bus.flush_i;
    assign bus.wb_data_o  = out_pkt.data;
    assign bus.wb_flags_o = out_pkt.flags;
    assign bus.wb_phys_o  = out_pkt.phys;
    assign bus.wb_al_id_o = out_pkt.al_id;
endmodule

// File: tb/tb_complex_fu_pipe.sv
// Directed bench for complex_fu_pipe: vector table plus flush/reset sequences,
// checked every cycle against a writeback schedule built from the issue stream.
module tb_complex_fu_pipe;
    localparam int ML = 3;
    localparam int DL = 8;
    localparam int NSCHED = 1024;

    localparam logic [7:0] MULT_L  = 8'h40, MULT_H  = 8'h41, MULTU_L = 8'h42, MULTU_H = 8'h43;
    localparam logic [7:0] DIV_L   = 8'h44, DIV_H   = 8'h45, DIVU_L  = 8'h46, DIVU_H  = 8'h47;
    localparam logic [7:0] SYSCALL = 8'h48;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] res;
        logic [5:0]  flags;
        logic [6:0]  phys;
        logic [6:0]  al;
        logic [31:0] d2;
        logic [31:0] exp_data;
        logic [5:0]  exp_flags;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    complex_fu_pipe_if #(.DATA_W(32), .FLAGS_W(6), .OPC_W(8), .PHYS_W(7), .AL_W(7)) bus ();

    complex_fu_pipe #(
        .DATA_W(32), .FLAGS_W(6), .OPC_W(8), .PHYS_W(7), .AL_W(7),
        .MUL_LAT(ML), .DIV_LAT(DL),
        .DIV_L(DIV_L), .DIV_H(DIV_H), .DIVU_L(DIVU_L), .DIVU_H(DIVU_H)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int div_free = 0;
    logic last_acc;
    logic [31:0] cur_exp_d;
    logic [5:0]  cur_exp_f;

    logic        exp_v  [NSCHED];
    logic [31:0] exp_d  [NSCHED];
    logic [5:0]  exp_f  [NSCHED];
    logic [6:0]  exp_ph [NSCHED];
    logic [6:0]  exp_al [NSCHED];

    vec_t tbl [10];

    function automatic logic is_div(input logic [7:0] op);
        return op == DIV_L || op == DIV_H || op == DIVU_L || op == DIVU_H;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NSCHED; i++) exp_v[i] = 1'b0;
        div_free = 0;
    endtask

    task automatic drive(input logic v, input vec_t x);
        bus.issue_valid_i = v;
        bus.opcode_i      = x.op;
        bus.alu_result_i  = x.res;
        bus.alu_flags_i   = x.flags;
        bus.phys_dest_i   = x.phys;
        bus.al_id_i       = x.al;
        bus.data2_i       = x.d2;
        cur_exp_d         = x.exp_data;
        cur_exp_f         = x.exp_flags;
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] res, input logic [5:0] fl,
                                input logic [6:0] ph, input logic [6:0] al);
        vec_t x;
        x = '{op, res, fl, ph, al, 32'h1, res, fl};
        return x;
    endfunction

    // Check the current cycle against the schedule, update the schedule, advance one cycle.
    task automatic tick();
        logic ev;
        int t;
        #1;
        last_acc = 1'b0;
        chk("ready", 32'(bus.ready_o), 32'(cyc >= div_free));
        ev = exp_v[cyc] && !bus.flush_i;
        chk("wb_valid", 32'(bus.wb_valid_o), 32'(ev));
        if (ev) begin
            chk("wb_data",  bus.wb_data_o,        exp_d[cyc]);
            chk("wb_flags", 32'(bus.wb_flags_o),  32'(exp_f[cyc]));
            chk("wb_phys",  32'(bus.wb_phys_o),   32'(exp_ph[cyc]));
            chk("wb_al_id", 32'(bus.wb_al_id_o),  32'(exp_al[cyc]));
        end
        exp_v[cyc] = 1'b0;
        if (bus.flush_i) begin
            for (int i = cyc + 1; i < NSCHED; i++) exp_v[i] = 1'b0;
            if (div_free > cyc + 1) div_free = cyc + 1;
        end else if (bus.issue_valid_i && cyc >= div_free) begin
            last_acc = 1'b1;
            t = cyc + (is_div(bus.opcode_i) ? DL : ML);
            assert (!exp_v[t]) else begin
                errors++;
                $display("FAIL collision cycle %0d: two writebacks scheduled for cycle %0d", cyc, t);
            end
            exp_v[t]  = 1'b1;
            exp_d[t]  = cur_exp_d;
            exp_f[t]  = cur_exp_f;
            exp_ph[t] = bus.phys_dest_i;
            exp_al[t] = bus.al_id_i;
            if (is_div(bus.opcode_i)) div_free = cyc + DL;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bus.issue_valid_i = 1'b0;
        bus.flush_i       = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vec_t z;
        int w;
        z = mk(MULT_L, 32'h0, 6'h0, 7'd0, 7'd0);

        tbl[0] = mk(MULT_L,  32'h0000_0C35, 6'h21, 7'd12, 7'd3);
        tbl[1] = mk(MULT_H,  32'hDEAD_BEEF, 6'h01, 7'd20, 7'd4);
        tbl[2] = mk(MULTU_L, 32'h1234_5678, 6'h3F, 7'd21, 7'd5);
        tbl[3] = mk(MULTU_H, 32'hFFFF_FFFF, 6'h10, 7'd22, 7'd6);
        tbl[4] = mk(SYSCALL, 32'h0000_0001, 6'h22, 7'd23, 7'd7);
        tbl[5] = mk(DIVU_L,  32'h0000_0007, 6'h20, 7'd40, 7'd8);
        tbl[6] = mk(MULT_H,  32'hA5A5_5A5A, 6'h0C, 7'd41, 7'd9);
        tbl[7] = mk(DIV_H,   32'h8000_0000, 6'h24, 7'd42, 7'd10);
        tbl[8] = mk(DIVU_H,  32'h0F0F_0F0F, 6'h05, 7'd127, 7'd127);
        tbl[9] = '{DIV_L, 32'hCAFE_F00D, 6'h20, 7'd43, 7'd11, 32'h0,
`ifdef COMPLEX_DIVZERO_EXC_EN
                   32'h0, 6'b010110};
`else
                   32'hCAFE_F00D, 6'h20};
`endif

        reset = 1'b0;
        bus.flush_i = 1'b0;
        drive(1'b0, z);
        clear_model();
        #1;
        chk("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
        chk("rst_wb_data",  bus.wb_data_o,       32'd0);
        chk("rst_wb_flags", 32'(bus.wb_flags_o), 32'd0);
        chk("rst_wb_phys",  32'(bus.wb_phys_o),  32'd0);
        chk("rst_wb_al_id", 32'(bus.wb_al_id_o), 32'd0);
        chk("rst_ready",    32'(bus.ready_o),    32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        idle(20);

        // Vector table: each entry issued as soon as the unit accepts, issue held high while blocked.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i]);
            w = 0;
            do begin
                tick();
                w++;
            end while (!last_acc && w < 2 * DL);
            if (!last_acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout vector %0d: not accepted after %0d cycles", i, w);
            end
        end
        idle(DL + 2);

        // Multiply then divide, flush pulsed with a concurrent issue: nothing may write back.
        drive(1'b1, mk(MULTU_H, 32'h1111_1111, 6'h01, 7'd50, 7'd20)); tick();
        drive(1'b1, mk(DIV_L,   32'h2222_2222, 6'h02, 7'd51, 7'd21)); tick();
        drive(1'b1, mk(MULT_L,  32'h3333_3333, 6'h03, 7'd52, 7'd22));
        bus.flush_i = 1'b1; tick();
        idle(DL + 2);

        // Flush landing on the exact writeback cycle of a multiply.
        drive(1'b1, mk(MULT_L, 32'h4444_4444, 6'h04, 7'd53, 7'd23)); tick();
        idle(ML - 1);
        bus.flush_i = 1'b1; tick();
        idle(ML + 2);

        // Asynchronous reset with a multiply and a divide in flight.
        drive(1'b1, mk(MULT_H, 32'h5555_5555, 6'h05, 7'd54, 7'd24)); tick();
        drive(1'b1, mk(DIVU_L, 32'h6666_6666, 6'h06, 7'd55, 7'd25)); tick();
        drive(1'b0, z);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
        chk("midrst_wb_data",  bus.wb_data_o,       32'd0);
        chk("midrst_ready",    32'(bus.ready_o),    32'd1);
        clear_model();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b1;
        idle(DL + 2);

        drive(1'b1, mk(SYSCALL, 32'h7777_7777, 6'h07, 7'd56, 7'd26)); tick();
        idle(ML + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/complex_fu_pipe.md
Name: complex_fu_pipe

Overview:
- Sequential wrapper around the combinational complex ALU (MULT/MULTU/DIV/DIVU/SYSCALL).
- Sits between the complex-issue select stage and the writeback/bypass network.
- Captures the ALU result, flags and destination tags at issue, then releases them on one writeback port after a fixed latency:
  - multiply class is fully pipelined;
  - divide class is non-pipelined and blocks issue while in flight.

Parameters:
- DATA_W, 32, data width (matches SIZE_DATA).
- FLAGS_W, 6, execution flag width (matches EXECUTION_FLAGS).
- OPC_W, 8, opcode width (matches SIZE_OPCODE_I).
- PHYS_W, 7, physical destination register tag width.
- AL_W, 7, active-list index width.
- MUL_LAT, 3, multiply-class latency in cycles; legal range 1..DIV_LAT-1.
- DIV_LAT, 8, divide-class latency in cycles; must be greater than MUL_LAT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid_i  in  1  issue packet present this cycle.
- ready_o  out  1  unit can accept an issue this cycle.
- opcode_i  in  OPC_W  opcode of the issuing op.
- data2_i  in  DATA_W  second source operand (used only by the optional feature).
- alu_result_i  in  DATA_W  complex ALU result_o for this op.
- alu_flags_i  in  FLAGS_W  complex ALU flags_o for this op.
- phys_dest_i  in  PHYS_W  destination physical register.
- al_id_i  in  AL_W  active-list index.
- flush_i  in  1  pipeline flush (mispredict or exception recovery).
- wb_valid_o  out  1  writeback packet valid.
- wb_data_o  out  DATA_W  writeback result.
- wb_flags_o  out  FLAGS_W  writeback flags.
- wb_phys_o  out  PHYS_W  writeback destination tag.
- wb_al_id_o  out  AL_W  writeback active-list index.

Behaviour:
- Reset (reset low, asynchronous):
  - all stage valid bits clear and the divide counter is 0;
  - wb_valid_o=0 and wb data, flags and tag outputs are 0;
  - ready_o=1.
- Accept rule: an issue is accepted in cycle N only if issue_valid_i=1, ready_o=1 and flush_i=0. Otherwise it is dropped, with no state change.
- Classification:
  - opcode equal to DIV_L, DIV_H, DIVU_L or DIVU_H selects the divide class;
  - every other opcode, including SYSCALL, selects the multiply class.
- Multiply class:
  - the captured packet is {result, flags, phys, al_id};
  - it shifts through a MUL_LAT-deep valid-tagged register chain;
  - wb_valid_o=1 in cycle N+MUL_LAT;
  - back-to-back accepts every cycle are allowed.
- Divide class:
  - the packet is held in a single holding register;
  - a down-counter is loaded with DIV_LAT on accept;
  - ready_o=0 in cycles N+1 .. N+DIV_LAT-1;
  - writeback occurs in cycle N+DIV_LAT, and ready_o=1 again in that same cycle.
- No writeback collisions: because MUL_LAT < DIV_LAT and issue is blocked while a divide is busy, no two packets reach writeback in the same cycle. The bench asserts this.
- Writeback mux: the output register takes either the multiply-chain tail or the divide holding register, whichever is valid.
- Outputs: all wb_* outputs are registered except that wb_valid_o is gated with ~flush_i.
- Flush in cycle F:
  - wb_valid_o=0 in cycle F;
  - all multiply stage valids, the divide valid and the counter clear at the F edge;
  - ready_o=1 from F+1;
  - no stale writeback ever appears after F.
- Simultaneous events:
  - flush together with issue: flush wins and the issue is dropped;
  - divide completion in cycle N+DIV_LAT together with a new issue: the new issue is accepted.
- Reset mid-operation discards everything in flight immediately.
- Data fields of invalid entries hold their last value (don't-care); checks apply only when the matching valid is 1.

Optional Feature:
- Macro: COMPLEX_DIVZERO_EXC_EN.
- Defined: for a divide-class op with data2_i==0, the captured result is forced to 0 and the captured flags are {0,1,0,1,1,0}, i.e. executed plus exception set. Timing is unchanged.
- Undefined: alu_result_i and alu_flags_i pass through unmodified, and data2_i is unused.

Test Plan:
- Reset release, no issue for 20 cycles -> wb_valid_o=0 and ready_o=1 throughout.
- MULT_L accepted cycle 5 with result 0x0000_0C35, phys 12, al 3 -> wb_valid_o=1 only in cycle 8 carrying 0x0000_0C35, phys 12, al 3; wb_flags_o equals the alu_flags_i presented at issue.
- Four multiply-class ops issued in cycles 10-13 -> four writebacks in cycles 13-16, in order, with matching tags.
- DIVU_L issued cycle 20 (result 0x7), then issue_valid_i held high -> ready_o=0 in cycles 21-27; writeback 0x7 in cycle 28; next op accepted cycle 28.
- MULTU_H accepted cycle 30, DIV_L accepted cycle 31, flush_i pulsed cycle 32 -> no writeback in cycles 32-40; ready_o=1 from cycle 33.
- With COMPLEX_DIVZERO_EXC_EN defined, DIV_L with data2_i=0 accepted cycle 50 -> cycle 58 writeback with data 0 and flags exception bit (bit 1) set; without the macro, the ALU's values are written back unchanged.
